rx78_vram_arbiter: RTL

// Sequences the six 8K VRAM planes (fg1..fg3, bg1..bg3) through a single shared address/data port.

---
 rtl/rx78_vram_arbiter.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/rx78_vram_arbiter.sv
// Shared-port arbiter for the six RX-78 VRAM planes: CPU reads/writes through the
// bank masks and the video fetch sweeps the planes, with video taking priority.
module rx78_vram_arbiter #(
    parameter int ADDR_W = 13,
    parameter int PLANES = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_W-1:0]     cpu_addr,
    input  logic [7:0]            cpu_din,
    input  logic [PLANES-1:0]     rd_bank,
    input  logic [PLANES-1:0]     wr_bank,
    output logic [7:0]            cpu_dout,
    output logic                  cpu_ack,
    output logic                  cpu_wait_n,
    input  logic                  vid_req,
    input  logic [ADDR_W-1:0]     vid_addr,
    output logic [8*PLANES-1:0]   vid_data,
    output logic                  vid_valid,
    output logic                  vid_busy,
    output logic                  vid_ovr,
    output logic [ADDR_W-1:0]     ram_addr,
    output logic [7:0]            ram_din,
    output logic [PLANES-1:0]     ram_ce_n,
    output logic                  ram_we_n,
    input  logic [7:0]            ram_q
);

    localparam int PW = (PLANES > 1) ? $clog2(PLANES) : 1;
    localparam logic [PW-1:0] LAST_PLANE = PW'(PLANES - 1);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] CPU_WR   = 3'd1;
    localparam logic [2:0] CPU_RD   = 3'd2;
    localparam logic [2:0] CPU_WT   = 3'd3;
    localparam logic [2:0] CPU_ACK  = 3'd4;
    localparam logic [2:0] VID      = 3'd5;
    localparam logic [2:0] VID_CAP  = 3'd6;
    localparam logic [2:0] VID_DONE = 3'd7;

    logic [2:0]              state;
    logic [PW-1:0]           vplane;
    logic [PW-1:0]           vprev;
    logic                    vid_pend;
    logic [ADDR_W-1:0]       vid_addr_q;
    logic [ADDR_W-1:0]       vaddr_eff;
    logic [8*(PLANES-1)-1:0] shadow;

    // A strobe arriving in the dispatch cycle itself must start the sweep at once.
    assign vaddr_eff  = vid_pend ? vid_addr_q : vid_addr;
    assign vprev      = vplane - 1'b1;
    assign vid_busy   = vid_pend;
    assign cpu_wait_n = ~(cpu_req & ~cpu_ack);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            vplane     <= '0;
            vid_pend   <= 1'b0;
            vid_addr_q <= '0;
            shadow     <= '0;
            vid_data   <= '0;
            vid_valid  <= 1'b0;
            vid_ovr    <= 1'b0;
            cpu_dout   <= '0;
            cpu_ack    <= 1'b0;
            ram_addr   <= '0;
            ram_din    <= '0;
            ram_ce_n   <= '1;
            ram_we_n   <= 1'b1;
        end else begin
            ram_ce_n  <= '1;
            ram_we_n  <= 1'b1;
            cpu_ack   <= 1'b0;
            vid_valid <= 1'b0;

            if (vid_req) begin
                if (vid_pend) begin
                    vid_ovr <= 1'b1;
                end else begin
                    vid_pend   <= 1'b1;
                    vid_addr_q <= vid_addr;
                end
            end

            case (state)
                // VID_DONE dispatches like IDLE so a CPU access queued behind a
                // fetch starts back-to-back with the vid_valid cycle.
                IDLE, VID_DONE: begin
                    if (vid_pend || vid_req) begin
                        state    <= VID;
                        vplane   <= '0;
                        ram_addr <= vaddr_eff;
                        ram_ce_n <= ~PLANES'(1);
                    end else if (cpu_req) begin
                        ram_addr <= cpu_addr;
                        ram_din  <= cpu_din;
                        if (cpu_we) begin
                            ram_ce_n <= ~wr_bank;
                            ram_we_n <= 1'b0;
                            state    <= CPU_WR;
                        end else begin
                            ram_ce_n <= ~rd_bank;
                            state    <= CPU_RD;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                CPU_WR: begin
                    cpu_ack <= 1'b1;
                    state   <= CPU_ACK;
                end
                CPU_RD: state <= CPU_WT;
                CPU_WT: begin
                    cpu_dout <= ram_q;
                    cpu_ack  <= 1'b1;
                    state    <= CPU_ACK;
                end
                CPU_ACK: state <= IDLE;
                // ram_q here belongs to the plane enabled one cycle earlier.
                VID: begin
                    if (vplane != '0)
                        shadow[8*int'(vprev) +: 8] <= ram_q;
                    if (vplane == LAST_PLANE) begin
                        state <= VID_CAP;
                    end else begin
                        vplane   <= vplane + 1'b1;
                        ram_ce_n <= ~(PLANES'(1) << (vplane + 1'b1));
                    end
                end
                VID_CAP: begin
                    vid_data  <= {ram_q, shadow};
                    vid_valid <= 1'b1;
                    vid_pend  <= 1'b0;
                    state     <= VID_DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
